// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants for the fetch stage: reset PC, state encoding,
// decode field positions and the NOP word.
package instr_fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 26;
  localparam int FUNC_MSB = 5;
  localparam int FUNC_LSB = 0;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_DRAIN = 1'b1
  } ifu_state_e;

  // Instruction addresses are always word aligned; low bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Small synchronous FIFO with first-word-fall-through read, used both for
// returned instructions and for the in-order PC tags of outstanding reads.
// Flush wins over push/pop; push is accepted when full only alongside a pop.
module ifu_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [WIDTH-1:0]        wdata,
  output logic [WIDTH-1:0]        rdata,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Occupancy flags and next pointer values.
  always_comb begin
    count    = wr_ptr_q - rd_ptr_q;
    full     = (count == (AW+1)'(DEPTH));
    empty    = (wr_ptr_q == rd_ptr_q);
    do_push  = push && !flush && (!full || pop);
    do_pop   = pop && !flush && !empty;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = flush ? wr_ptr_q : rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; contents need no reset because empty masks them.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, issues word reads with credit-based flow
// control, buffers responses and hands them to decode.  A redirect flushes
// the buffer and drains responses still in flight before refetching.
// Optional macro IFU_BYPASS_EN: forward a response straight to decode when
// the buffer is empty, saving one cycle of fetch-to-decode latency.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_pc4,
  output logic [5:0]  opc,
  output logic [5:0]  func
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);

  ifu_state_e    state_q, state_d;
  logic [31:0]   pc_q, pc_d;

  logic [CW-1:0] rsp_count, tag_count, out_left;
  logic          rsp_full, rsp_empty, tag_full, tag_empty;
  logic [63:0]   rsp_head;
  logic [31:0]   tag_head;
  logic          rsp_valid, rsp_push, rsp_pop, tag_push;
  logic [CW:0]   credits_used;
  logic [31:0]   head_pc, head_instr;
`ifdef IFU_BYPASS_EN
  logic          bypass;
`endif

  // The tag queue occupancy is the number of outstanding reads.
  assign credits_used = {1'b0, rsp_count} + {1'b0, tag_count};

  // Request, response routing and decode-side outputs.
  always_comb begin
    rsp_valid = imem_rvalid && !tag_empty;
    imem_req  = !rst && !redirect_valid && (state_q == ST_FETCH) &&
                !tag_full && !rsp_full && (credits_used < DEPTH_C);
    imem_addr = pc_q;
    tag_push  = imem_req && imem_gnt;
`ifdef IFU_BYPASS_EN
    bypass     = rsp_valid && rsp_empty && (state_q == ST_FETCH) && !redirect_valid;
    rsp_push   = rsp_valid && (state_q == ST_FETCH) && !redirect_valid &&
                 !(bypass && dec_ready);
    head_pc    = bypass ? tag_head   : rsp_head[63:32];
    head_instr = bypass ? imem_rdata : rsp_head[31:0];
    dec_valid  = !rst && (!rsp_empty || bypass);
`else
    rsp_push   = rsp_valid && (state_q == ST_FETCH) && !redirect_valid;
    head_pc    = rsp_head[63:32];
    head_instr = rsp_head[31:0];
    dec_valid  = !rst && !rsp_empty;
`endif
    rsp_pop   = !rsp_empty && dec_ready && !redirect_valid;
    dec_instr = dec_valid ? head_instr : NOP_WORD;
    dec_pc    = dec_valid ? head_pc : 32'd0;
    dec_pc4   = dec_valid ? head_pc + 32'd4 : 32'd0;
    opc       = dec_instr[OPC_MSB:OPC_LSB];
    func      = dec_instr[FUNC_MSB:FUNC_LSB];
  end

  // Next PC and state; a redirect overrides everything else.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    out_left = tag_count - {{(CW-1){1'b0}}, rsp_valid};
    if (redirect_valid) begin
      pc_d    = word_align(redirect_pc);
      state_d = (out_left != '0) ? ST_DRAIN : ST_FETCH;
    end else begin
      if (tag_push) begin
        pc_d = pc_q + 32'd4;
      end
      if ((state_q == ST_DRAIN) && (out_left == '0)) begin
        state_d = ST_FETCH;
      end
    end
  end

  // PC and state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  ifu_fifo #(.DEPTH(DEPTH), .WIDTH(64)) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_push),
    .pop   (rsp_pop),
    .flush (redirect_valid),
    .wdata ({tag_head, imem_rdata}),
    .rdata (rsp_head),
    .count (rsp_count),
    .full  (rsp_full),
    .empty (rsp_empty)
  );

  // Tags are never flushed: dropped responses still pop their own tag.
  ifu_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tag_push),
    .pop   (rsp_valid),
    .flush (1'b0),
    .wdata (pc_q),
    .rdata (tag_head),
    .count (tag_count),
    .full  (tag_full),
    .empty (tag_empty)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a 1-cycle-latency memory model, a scoreboard
// of expected {pc, instr} pairs and directed plus random phases.
module tb_instr_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] epoch;
  } pend_t;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [31:0] dec_pc4;
  logic [5:0]  opc;
  logic [5:0]  func;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] epoch    = 32'd0;
  logic        gnt_en;
  logic        rsp_en;

  exp_t        exp_q[$];
  pend_t       pend[$];
  logic [31:0] req_log[$];

  logic        s_req, s_dvalid;
  logic [31:0] s_addr, s_pc;
  logic [5:0]  s_opc;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .dec_pc4        (dec_pc4),
    .opc            (opc),
    .func           (func)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, got running expected finished");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h8C08_0004;
    if (a == 32'h0040_0004) return 32'hAC09_0008;
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // One clock: drive response, sample at negedge, grant, score, advance.
  task automatic cyc();
    pend_t p;
    exp_t  e;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    if (rsp_en && pend.size() > 0) begin
      p           = pend.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(p.addr);
      if (p.epoch == epoch && !redirect_valid && !rst) begin
        e.pc    = p.addr;
        e.instr = mem_word(p.addr);
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
    s_req    = imem_req;
    s_addr   = imem_addr;
    s_dvalid = dec_valid;
    s_pc     = dec_pc;
    s_opc    = opc;
    imem_gnt = imem_req && gnt_en;
    if (imem_gnt) begin
      p.addr  = imem_addr;
      p.epoch = epoch;
      pend.push_back(p);
      req_log.push_back(imem_addr);
    end
    if (dec_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_valid", 32'(dec_valid), 32'd0);
      end else begin
        e = exp_q[0];
        check_eq("dec_instr", dec_instr, e.instr);
        check_eq("dec_pc", dec_pc, e.pc);
        check_eq("dec_pc4", dec_pc4, e.pc + 32'd4);
        check_eq("opc", 32'(opc), 32'(e.instr[31:26]));
        check_eq("func", 32'(func), 32'(e.instr[5:0]));
        if (dec_ready && !redirect_valid && !rst) begin
          void'(exp_q.pop_front());
          $display("retire pc=%h instr=%h", e.pc, e.instr);
        end
      end
    end
    if (redirect_valid || rst) begin
      exp_q.delete();
      epoch++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_imem_req"}, 32'(imem_req), 32'd0);
    check_eq({tag, "_dec_valid"}, 32'(dec_valid), 32'd0);
    check_eq({tag, "_dec_instr"}, dec_instr, 32'd0);
    check_eq({tag, "_dec_pc"}, dec_pc, 32'd0);
    check_eq({tag, "_dec_pc4"}, dec_pc4, 32'd0);
    check_eq({tag, "_opc"}, 32'(opc), 32'd0);
    check_eq({tag, "_func"}, 32'(func), 32'd0);
  endtask

  initial begin
    rst = 1'b1; dec_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    gnt_en = 1'b1; rsp_en = 1'b1;
    @(posedge clk); #1;
    cyc();
    check_reset_outputs("por");
    cyc();

    // Reset release with decode stalled: latency, address order, credits.
    rst = 1'b0;
    cyc();
    check_eq("c0_req", 32'(s_req), 32'd1);
    check_eq("c0_addr", s_addr, 32'h0040_0000);
    cyc();
    check_eq("c1_dvalid", 32'(s_dvalid), 32'd0);
    cyc();
    check_eq("c2_dvalid", 32'(s_dvalid), 32'd1);
    check_eq("c2_opc", 32'(s_opc), 32'h23);
    check_eq("c2_pc", s_pc, 32'h0040_0000);
    cyc();
    cyc();
    check_eq("stall_req_off", 32'(s_req), 32'd0);
    check_eq("stall_req_count", 32'(req_log.size()), 32'd2);
    check_eq("addr_seq0", req_log[0], 32'h0040_0000);
    check_eq("addr_seq1", req_log[1], 32'h0040_0004);
    dec_ready = 1'b1;
    repeat (8) cyc();

    // Redirect with two reads outstanding: both drained and dropped.
    rsp_en = 1'b0;
    repeat (6) cyc();
    check_eq("credit_stop", 32'(s_req), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0100;
    cyc();
    redirect_valid = 1'b0;
    check_eq("redir_req", 32'(s_req), 32'd0);
    rsp_en = 1'b1;
    cyc();
    check_eq("drain_a_req", 32'(s_req), 32'd0);
    check_eq("drain_a_dvalid", 32'(s_dvalid), 32'd0);
    cyc();
    check_eq("drain_b_req", 32'(s_req), 32'd0);
    cyc();
    check_eq("drain_exit_req", 32'(s_req), 32'd1);
    check_eq("drain_exit_addr", s_addr, 32'h0040_0100);

    // Redirect coinciding with rvalid and a ready decode; unaligned target.
    cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0202;
    cyc();
    redirect_valid = 1'b0;
    check_eq("redir2_req", 32'(s_req), 32'd0);
    check_eq("redir2_dvalid", 32'(s_dvalid), 32'd1);
    cyc();
    check_eq("redir2_flushed", 32'(s_dvalid), 32'd0);
    check_eq("redir2_req_next", 32'(s_req), 32'd1);
    check_eq("redir2_addr", s_addr, 32'h0040_0200);

    // PC wrap from the top of the address space.
    gnt_en = 1'b0;
    repeat (4) cyc();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect_valid = 1'b0;
    gnt_en = 1'b1;
    cyc();
    check_eq("wrap_pre_addr", s_addr, 32'hFFFF_FFFC);
    cyc();
    check_eq("wrap_addr", s_addr, 32'h0000_0000);
    gnt_en = 1'b0;
    repeat (4) cyc();

    // Reset with one read in flight; its late response must be ignored.
    gnt_en = 1'b1; rsp_en = 1'b0;
    cyc();
    check_eq("t6_grant", 32'(s_req), 32'd1);
    gnt_en = 1'b0; rst = 1'b1;
    cyc();
    check_reset_outputs("mid");
    rst = 1'b0; rsp_en = 1'b1; gnt_en = 1'b1;
    cyc();
    check_eq("rst_pc_req", 32'(s_req), 32'd1);
    check_eq("rst_pc_addr", s_addr, 32'h0040_0000);
    cyc();
    check_eq("stale_ignored", 32'(s_dvalid), 32'd0);
    cyc();
    check_eq("post_rst_dvalid", 32'(s_dvalid), 32'd1);
    check_eq("post_rst_pc", s_pc, 32'h0040_0000);

    // Random traffic with occasional redirects.
    repeat (60) begin
      dec_ready      = 1'($urandom_range(0, 1));
      gnt_en         = 1'($urandom_range(0, 1));
      rsp_en         = 1'($urandom_range(0, 1));
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom;
      cyc();
    end
    redirect_valid = 1'b0; gnt_en = 1'b0; rsp_en = 1'b1; dec_ready = 1'b1;
    repeat (8) cyc();
    check_eq("final_drained", 32'(exp_q.size()), 32'd0);
    check_eq("final_dvalid", 32'(s_dvalid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
